uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit holding stage directly upstream of the UART TX shifter. It accepts bytes written by the register interface, either into a single-entry THR (non-FIFO mode) or a DEPTH-entry FIFO (FIFO mode). It presents the head byte to the shifter over a valid/ready handshake and generates the THRE and TEMT line-status flags plus a THRE-rise interrupt pulse.

Parameters:
DEPTH, 16, FIFO entries in FIFO mode; power of two, 2..256
WIDTH, 8, data bits per entry
CNT_W, 5, count width; must equal clog2(DEPTH)+1

Ports:
clk_in  input  1  block clock
rst_in  input  1  synchronous active-high reset
fifo_en_in  input  1  1 = FIFO mode (DEPTH entries), 0 = THR mode (1 entry)
fifo_clr_in  input  1  single-cycle pulse; flushes all stored bytes
wr_en_in  input  1  write strobe for wdata_in (THR write)
wdata_in  input  WIDTH  byte to transmit
tx_data_out  output  WIDTH  head byte to shifter; valid only while tx_valid_out=1
tx_valid_out  output  1  head entry available
tx_ready_in  input  1  shifter can accept a byte this cycle
tx_busy_in  input  1  shifter is still serialising a frame
count_out  output  CNT_W  stored entries, 0..DEPTH (0..1 in THR mode)
thre_out  output  1  holding register/FIFO empty
temt_out  output  1  transmitter fully empty
overflow_out  output  1  one-cycle pulse: write dropped because storage was full
thre_rise_out  output  1  one-cycle pulse when thre_out goes 0->1

Behaviour:
- Reset (rst_in=1 at a clock edge): pointers=0, count_out=0, tx_valid_out=0, tx_data_out=0, thre_out=1, temt_out=1, overflow_out=0, thre_rise_out=0. This holds regardless of the other inputs and takes effect immediately even mid-transfer.
- Capacity: cap = DEPTH when fifo_en_in=1, cap = 1 when fifo_en_in=0.
- Pop: occurs on a clock edge where tx_valid_out=1 and tx_ready_in=1. The read pointer advances modulo DEPTH and count decrements.
- Push: occurs when wr_en_in=1 and either count<cap or a pop happens in the same cycle. wdata_in is stored at the write pointer, which advances modulo DEPTH, and count increments.
- Simultaneous push and pop: count is unchanged. When count=1, the popped byte is the old head and the new byte becomes the head next cycle.
- Overflow: wr_en_in=1, count=cap and no pop. The byte is dropped, the contents are untouched, and overflow_out=1 for exactly the next cycle.
- tx_data_out is first-word-fall-through and registered. It shows mem[rd_ptr] the cycle after a push into an empty store, so write-to-valid latency is 1 cycle. tx_valid_out = (count!=0).
- Flush on fifo_clr_in=1: pointers and count go to 0 and tx_valid_out goes to 0 next cycle. Flush wins over a same-cycle push or pop: the write is dropped with no overflow pulse, and no pop is counted.
- A change of fifo_en_in (sampled edge vs previous registered value) performs the same flush as fifo_clr_in.
- A pop request with count=0 is a no-op; tx_ready_in is ignored when tx_valid_out=0.
- thre_out = (count==0), registered.
- temt_out = (count==0) && !tx_busy_in, registered; it lags tx_busy_in by 1 cycle.
- thre_rise_out is high for 1 cycle after the cycle in which count transitions from nonzero to 0, whether by pop or by flush. It does not fire out of reset.
- Wrap-around: the pointers are log2(DEPTH) bits and the count is CNT_W bits. Full is count==cap, never a pointer comparison.
- Memory contents are not reset; only control state is.

Test Plan:
- Reset then idle, tx_ready_in=1 -> count_out=0, tx_valid_out=0, thre_out=1, temt_out=1, no pulses.
- THR mode: write 0xA5, tx_ready_in=0 -> next cycle tx_valid_out=1, tx_data_out=0xA5, thre_out=0. A second write 0x3C -> overflow_out pulse and head stays 0xA5. Then tx_ready_in=1 for one cycle -> count_out=0 and thre_rise_out pulses once.
- FIFO mode: write 0x00..0x0F with tx_ready_in=0 -> count_out=16. A 17th write 0xFF -> overflow_out=1 and count stays 16. Then drain with tx_ready_in=1 -> bytes 0x00..0x0F emerge in order, thre_rise_out pulses after the last.
- FIFO full (16) with wr_en_in=1 (0x77) and a pop in the same cycle -> no overflow, count stays 16, 0x77 emerges 16th after the current head.
- Write 3 bytes, then assert fifo_clr_in together with wr_en_in=1 (0x55) -> count_out=0 next cycle, no overflow, thre_rise_out pulses, 0x55 never appears. Toggling fifo_en_in with 2 bytes stored gives the same flush.
- Drain the last byte while tx_busy_in=1 for 10 cycles -> thre_out=1 immediately, temt_out=0 until 1 cycle after tx_busy_in falls. Asserting rst_in mid-drain -> all outputs take their reset values next cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmit holding stage: single-entry THR or DEPTH-entry FIFO feeding the
// TX shifter over valid/ready, with THRE/TEMT status and a THRE-rise pulse.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             fifo_en_in,
    input  logic             fifo_clr_in,
    input  logic             wr_en_in,
    input  logic [WIDTH-1:0] wdata_in,
    output logic [WIDTH-1:0] tx_data_out,
    output logic             tx_valid_out,
    input  logic             tx_ready_in,
    input  logic             tx_busy_in,
    output logic [CNT_W-1:0] count_out,
    output logic             thre_out,
    output logic             temt_out,
    output logic             overflow_out,
    output logic             thre_rise_out
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CAP_FIFO = CNT_W'(DEPTH);

    // Storage is deliberately left unreset; only control state is cleared.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             fifo_en_q;
    logic             thre_q, thre_d;
    logic             temt_q, temt_d;
    logic             ovf_q, ovf_d;
    logic             rise_q, rise_d;

    logic [CNT_W-1:0] cap;
    logic [AW-1:0]    rd_ptr_inc;
    logic             flush;
    logic             valid;
    logic             pop;
    logic             push;
    logic             full;

    // Handshake decode and next-state for pointers, count, head data and flags.
    always_comb begin
        cap        = fifo_en_in ? CAP_FIFO : CNT_ONE;
        rd_ptr_inc = rd_ptr_q + PTR_ONE;
        // A mode change empties storage exactly like an explicit clear.
        flush      = fifo_clr_in | (fifo_en_in != fifo_en_q);
        valid      = (count_q != CNT_ZERO);
        full       = (count_q >= cap);
        pop        = valid & tx_ready_in & ~flush;
        push       = wr_en_in & ~flush & (~full | pop);

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_inc;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end

        // Registered fall-through head: the incoming byte becomes head when the
        // store is (or is about to be) empty, otherwise the next stored entry.
        if (!flush) begin
            if (push && (count_q == CNT_ZERO || (count_q == CNT_ONE && pop))) begin
                tx_data_d = wdata_in;
            end else if (pop && count_q > CNT_ONE) begin
                tx_data_d = mem_q[rd_ptr_inc];
            end
        end

        ovf_d  = wr_en_in & ~flush & full & ~pop;
        thre_d = (count_d == CNT_ZERO);
        temt_d = (count_d == CNT_ZERO) & ~tx_busy_in;
        rise_d = (count_q != CNT_ZERO) & (count_d == CNT_ZERO);
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            tx_data_q <= '0;
            // Track the current mode so leaving reset does not look like a mode change.
            fifo_en_q <= fifo_en_in;
            thre_q    <= 1'b1;
            temt_q    <= 1'b1;
            ovf_q     <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            fifo_en_q <= fifo_en_in;
            thre_q    <= thre_d;
            temt_q    <= temt_d;
            ovf_q     <= ovf_d;
            rise_q    <= rise_d;
        end
    end

    // Data array write port.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            mem_q[wr_ptr_q] <= wdata_in;
        end
    end

    assign tx_data_out   = tx_data_q;
    assign tx_valid_out  = valid;
    assign count_out     = count_q;
    assign thre_out      = thre_q;
    assign temt_out      = temt_q;
    assign overflow_out  = ovf_q;
    assign thre_rise_out = rise_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, WIDTH=8).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_en;
    logic       fifo_clr;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic [4:0] count;
    logic       thre;
    logic       temt;
    logic       ovf;
    logic       rise;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .DEPTH(16),
        .WIDTH(8),
        .CNT_W(5)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .fifo_en_in   (fifo_en),
        .fifo_clr_in  (fifo_clr),
        .wr_en_in     (wr_en),
        .wdata_in     (wdata),
        .tx_data_out  (tx_data),
        .tx_valid_out (tx_valid),
        .tx_ready_in  (tx_ready),
        .tx_busy_in   (tx_busy),
        .count_out    (count),
        .thre_out     (thre),
        .temt_out     (temt),
        .overflow_out (ovf),
        .thre_rise_out(rise)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        fifo_en  = 1'b0;
        fifo_clr = 1'b0;
        wr_en    = 1'b0;
        wdata    = 8'h00;
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Idle after reset
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_thre", 32'(thre), 1);
        chk("rst_temt", 32'(temt), 1);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_rise", 32'(rise), 0);

        // THR mode: single entry
        tx_ready = 1'b0;
        wr_en = 1'b1; wdata = 8'hA5;
        tick();
        wr_en = 1'b0;
        chk("thr_valid", 32'(tx_valid), 1);
        chk("thr_data", 32'(tx_data), 32'hA5);
        chk("thr_thre", 32'(thre), 0);
        chk("thr_temt", 32'(temt), 0);
        chk("thr_count", 32'(count), 1);
        wr_en = 1'b1; wdata = 8'h3C;
        tick();
        wr_en = 1'b0;
        chk("thr_ovf", 32'(ovf), 1);
        chk("thr_ovf_head", 32'(tx_data), 32'hA5);
        chk("thr_ovf_count", 32'(count), 1);
        tick();
        chk("thr_ovf_once", 32'(ovf), 0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("thr_pop_count", 32'(count), 0);
        chk("thr_pop_valid", 32'(tx_valid), 0);
        chk("thr_pop_thre", 32'(thre), 1);
        chk("thr_rise", 32'(rise), 1);
        tick();
        chk("thr_rise_once", 32'(rise), 0);

        // FIFO mode: fill, overflow, drain in order
        fifo_en = 1'b1;
        tick();
        chk("mode_empty_norise", 32'(rise), 0);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("fifo_full_count", 32'(count), 16);
        chk("fifo_head", 32'(tx_data), 0);
        wr_en = 1'b1; wdata = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("fifo_ovf", 32'(ovf), 1);
        chk("fifo_ovf_count", 32'(count), 16);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(tx_data), 32'(i));
            chk($sformatf("drain_valid_%0d", i), 32'(tx_valid), 1);
            tick();
        end
        tx_ready = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_rise", 32'(rise), 1);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wdata = 8'(16 + i);
            tick();
        end
        wr_en = 1'b1; wdata = 8'h77; tx_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("pp_ovf", 32'(ovf), 0);
        chk("pp_count", 32'(count), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("pp_data_%0d", k), 32'(tx_data), (k < 15) ? 32'(8'h11 + k) : 32'h77);
            tick();
        end
        tx_ready = 1'b0;
        chk("pp_empty", 32'(count), 0);

        // Clear wins over a same-cycle write
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wdata = 8'(i);
            tick();
        end
        wr_en = 1'b1; wdata = 8'h55; fifo_clr = 1'b1;
        tick();
        wr_en = 1'b0; fifo_clr = 1'b0;
        chk("clr_count", 32'(count), 0);
        chk("clr_valid", 32'(tx_valid), 0);
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_rise", 32'(rise), 1);
        wr_en = 1'b1; wdata = 8'h66;
        tick();
        wdata = 8'h67;
        chk("clr_next_head", 32'(tx_data), 32'h66);
        chk("clr_next_count", 32'(count), 1);
        tick();
        wr_en = 1'b0;
        chk("mode_pre_count", 32'(count), 2);
        fifo_en = 1'b0;
        tick();
        chk("mode_flush_count", 32'(count), 0);
        chk("mode_flush_rise", 32'(rise), 1);
        chk("mode_flush_thre", 32'(thre), 1);

        // Drain while the shifter is still busy
        wr_en = 1'b1; wdata = 8'h42; tx_busy = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("busy_head", 32'(tx_data), 32'h42);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("busy_thre", 32'(thre), 1);
        chk("busy_temt0", 32'(temt), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("busy_temt_hold_%0d", i), 32'(temt), 0);
        end
        tx_busy = 1'b0;
        #1;
        chk("busy_temt_lag", 32'(temt), 0);
        tick();
        chk("busy_temt_set", 32'(temt), 1);

        // Reset in the middle of a drain
        fifo_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wdata = 8'hC0 + 8'(i);
            tick();
        end
        wr_en = 1'b0; tx_ready = 1'b1; tx_busy = 1'b1;
        tick();
        chk("mid_count", 32'(count), 2);
        chk("mid_data", 32'(tx_data), 32'hC1);
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(tx_valid), 0);
        chk("mid_rst_data", 32'(tx_data), 0);
        chk("mid_rst_thre", 32'(thre), 1);
        chk("mid_rst_temt", 32'(temt), 1);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_rise", 32'(rise), 0);
        rst = 1'b0; tx_ready = 1'b0; tx_busy = 1'b0;
        tick();
        chk("post_rst_norise", 32'(rise), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
